// File: rtl/slicer_ref.sv
// slicer_ref: 4-PAM Gray decision slicer with block-averaged mean-|x| threshold/reference estimation.
// Define SLICER_ERR_EN to compile in the saturated slicer-error output; otherwise err is tied to zero.
module slicer_ref #(
  parameter int                 ACC_LOG2    = 12,
  parameter logic signed [17:0] INIT_THRESH = 18'sd87381
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sym_en,
  input  logic signed [17:0] dec_in,
  output logic [1:0]         slicer_out,
  output logic signed [17:0] dec_val,
  output logic signed [17:0] err,
  output logic               out_valid,
  output logic signed [17:0] thresh,
  output logic signed [17:0] ref_lvl,
  output logic               ref_valid
);

  localparam int ACC_W = 17 + ACC_LOG2;
  localparam logic signed [17:0] MAX_POS = 18'sd131071;

  // Outer level is 1.5x the mean |x|, clipped to positive full scale.
  function automatic logic signed [17:0] outerOf(input logic signed [17:0] m);
    logic signed [18:0] s;
    s = 19'(m) + 19'(m >>> 1);
    if (s > 19'sd131071)
      return MAX_POS;
    else
      return s[17:0];
  endfunction

  localparam logic signed [17:0] INIT_REF = outerOf(INIT_THRESH);

  typedef enum logic {INIT, TRACK} stateT;

  stateT state;
  stateT stateNext;

  logic [16:0]               absIn;
  logic [16:0]               absX;
  logic                      xSign;
  logic                      v1;
  logic [ACC_W-1:0]          acc;
  logic [ACC_W-1:0]          accSum;
  logic [ACC_LOG2-1:0]       cnt;
  logic                      blockDone;
  logic [16:0]               mNew;
  logic signed [17:0]        activeThresh;
  logic signed [17:0]        innerLvl;
  logic signed [17:0]        outerLvl;
  logic signed [17:0]        levelMag;
  logic                      isOuter;
  logic [1:0]                slcNext;
  logic signed [17:0]        dvNext;

  // The most negative sample has no positive twin, so it clips to full scale.
  always_comb begin
    absIn = dec_in[16:0];
    if (dec_in[17]) begin
      if (dec_in[16:0] == 17'd0)
        absIn = 17'h1FFFF;
      else
        absIn = ~dec_in[16:0] + 17'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      absX  <= '0;
      xSign <= 1'b0;
      v1    <= 1'b0;
    end else begin
      v1 <= sym_en;
      if (sym_en) begin
        absX  <= absIn;
        xSign <= dec_in[17];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= INIT;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (state == INIT && blockDone)
      stateNext = TRACK;
  end

  // Until the first block completes the threshold is pinned to its start value.
  always_comb begin
    activeThresh = thresh;
    if (state == INIT)
      activeThresh = INIT_THRESH;
    innerLvl = activeThresh >>> 1;
    outerLvl = outerOf(activeThresh);
    isOuter  = $signed({1'b0, absX}) >= activeThresh;
    levelMag = isOuter ? outerLvl : innerLvl;
    dvNext   = xSign ? -levelMag : levelMag;
    case ({xSign, isOuter})
      2'b00:   slcNext = 2'b11;
      2'b01:   slcNext = 2'b10;
      2'b10:   slcNext = 2'b01;
      default: slcNext = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slicer_out <= 2'b00;
      dec_val    <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        slicer_out <= slcNext;
        dec_val    <= dvNext;
      end
    end
  end

`ifdef SLICER_ERR_EN
  logic signed [17:0] xReg;
  logic signed [18:0] diff;
  logic signed [17:0] errNext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      xReg <= '0;
    else if (sym_en)
      xReg <= dec_in;
  end

  always_comb begin
    diff    = 19'(xReg) - 19'(dvNext);
    errNext = diff[17:0];
    if (diff > 19'sd131071)
      errNext = MAX_POS;
    else if (diff < -19'sd131072)
      errNext = -18'sd131072;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err <= '0;
    else if (v1)
      err <= errNext;
  end
`else
  assign err = '0;
`endif

  // The symbol that wraps the counter is folded into the block it closes.
  always_comb begin
    accSum    = acc + ACC_W'(absX);
    blockDone = v1 && (&cnt);
    mNew      = accSum[ACC_W-1:ACC_LOG2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      thresh    <= INIT_THRESH;
      ref_lvl   <= INIT_REF;
      ref_valid <= 1'b0;
    end else begin
      ref_valid <= blockDone;
      if (v1) begin
        cnt <= cnt + ACC_LOG2'(1);
        if (blockDone) begin
          acc     <= '0;
          thresh  <= $signed({1'b0, mNew});
          ref_lvl <= outerOf($signed({1'b0, mNew}));
        end else begin
          acc <= accSum;
        end
      end
    end
  end

endmodule

// File: tb/tb_slicer_ref.sv
// tb_slicer_ref: scoreboard bench for slicer_ref with 16-symbol estimation blocks.
// Expected decisions and reference updates are queued at issue time and checked by a monitor.
module tb_slicer_ref;

  logic               clk = 1'b0;
  logic               reset;
  logic               sym_en;
  logic signed [17:0] dec_in;
  logic [1:0]         slicer_out;
  logic signed [17:0] dec_val;
  logic signed [17:0] err;
  logic               out_valid;
  logic signed [17:0] thresh;
  logic signed [17:0] ref_lvl;
  logic               ref_valid;

  always #5 clk = ~clk;

  slicer_ref #(.ACC_LOG2(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .sym_en     (sym_en),
    .dec_in     (dec_in),
    .slicer_out (slicer_out),
    .dec_val    (dec_val),
    .err        (err),
    .out_valid  (out_valid),
    .thresh     (thresh),
    .ref_lvl    (ref_lvl),
    .ref_valid  (ref_valid)
  );

  typedef struct {
    logic [1:0]         sl;
    logic signed [17:0] dv;
    logic signed [17:0] er;
    bit                 last;
  } expT;

  typedef struct {
    logic signed [17:0] th;
    logic signed [17:0] rl;
  } refT;

  expT expQ[$];
  refT refQ[$];
  expT e;
  refT r;
  int  checks   = 0;
  int  failures = 0;
  logic [15:0] lfsr = 16'hACE1;

  function automatic logic signed [17:0] expErr(input logic signed [17:0] x,
                                                input logic signed [17:0] dv);
`ifdef SLICER_ERR_EN
    logic signed [18:0] d;
    d = 19'(x) - 19'(dv);
    if (d > 19'sd131071)
      return 18'sd131071;
    else if (d < -19'sd131072)
      return -18'sd131072;
    else
      return d[17:0];
`else
    return 18'sd0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic signed [31:0] act,
                             input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic signed [17:0] x, input logic [1:0] sl,
                               input logic signed [17:0] dv, input bit last);
    sym_en = 1'b1;
    dec_in = x;
    expQ.push_back('{sl, dv, expErr(x, dv), last});
    @(posedge clk);
    #1;
  endtask

  task automatic expectRef(input logic signed [17:0] th, input logic signed [17:0] rl);
    refQ.push_back('{th, rl});
  endtask

  task automatic idle(input int n);
    sym_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_slicerOut"}, slicer_out, 0);
    checkOutput({tag, "_decVal"},    dec_val,    0);
    checkOutput({tag, "_err"},       err,        0);
    checkOutput({tag, "_outValid"},  out_valid,  0);
    checkOutput({tag, "_refValid"},  ref_valid,  0);
    checkOutput({tag, "_thresh"},    thresh,     87381);
    checkOutput({tag, "_refLvl"},    ref_lvl,    131071);
  endtask

  // Monitor: every out_valid / ref_valid must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedOutValid", out_valid, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("slicerOut", slicer_out, e.sl);
          checkOutput("decVal",    dec_val,    e.dv);
          checkOutput("err",       err,        e.er);
          checkOutput("refTiming", ref_valid,  e.last);
        end
      end
      if (ref_valid) begin
        if (refQ.size() == 0) begin
          checkOutput("unexpectedRefValid", ref_valid, 0);
        end else begin
          r = refQ.pop_front();
          checkOutput("thresh", thresh,  r.th);
          checkOutput("refLvl", ref_lvl, r.rl);
        end
      end
    end
  end

  initial begin
    bit neg;
    bit ob;
    bit outer;
    logic signed [17:0] x;
    logic signed [17:0] dv;
    logic [1:0] sl;

    reset  = 1'b1;
    sym_en = 1'b0;
    dec_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    reset = 1'b0;
    idle(1);

    // Default threshold 87381: inner 43690, outer 131071.
    applyStimulus( 18'sd131071, 2'b10,  18'sd131071, 1'b0);
    applyStimulus( 18'sd43691,  2'b11,  18'sd43690,  1'b0);
    applyStimulus(-18'sd43691,  2'b01, -18'sd43690,  1'b0);
    applyStimulus(-18'sd131072, 2'b00, -18'sd131071, 1'b0);
    applyStimulus( 18'sd87381,  2'b10,  18'sd131071, 1'b0);
    applyStimulus( 18'sd87380,  2'b11,  18'sd43690,  1'b0);
    applyStimulus( 18'sd0,      2'b11,  18'sd43690,  1'b0);
    applyStimulus(-18'sd87381,  2'b00, -18'sd131071, 1'b0);
    idle(3);

    // Reset with a symbol in flight and a partial block accumulated.
    sym_en = 1'b1;
    dec_in = 18'sd12345;
    @(posedge clk);
    #1;
    sym_en = 1'b0;
    reset  = 1'b1;
    #1;
    checkResetValues("midReset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(4);

    // Full block of |x| = 60000 decided against the initial threshold.
    expectRef(18'sd60000, 18'sd90000);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0)
        applyStimulus( 18'sd60000, 2'b11,  18'sd43690, i == 15);
      else
        applyStimulus(-18'sd60000, 2'b01, -18'sd43690, i == 15);
    end
    // Immediately following symbols see thresh 60000: inner 30000, outer 90000.
    applyStimulus( 18'sd60000,  2'b10,  18'sd90000, 1'b0);
    applyStimulus( 18'sd59999,  2'b11,  18'sd30000, 1'b0);
    applyStimulus(-18'sd100000, 2'b00, -18'sd90000, 1'b0);
    applyStimulus(-18'sd20000,  2'b01, -18'sd30000, 1'b0);
    idle(3);
    checkOutput("holdSlicerOut", slicer_out, 2'b01);
    checkOutput("holdDecVal",    dec_val,    -30000);
    checkOutput("holdErr",       err,        expErr(-18'sd20000, -18'sd30000));
    checkOutput("holdOutValid",  out_valid,  0);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Full-scale block: reference must clip rather than wrap.
    expectRef(18'sd131071, 18'sd131071);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0)
        applyStimulus( 18'sd131071, 2'b10,  18'sd131071, i == 15);
      else
        applyStimulus(-18'sd131072, 2'b00, -18'sd131071, i == 15);
    end

    // Thresh 131071 now: inner 65535; this block pulls the mean to 43690.
    expectRef(18'sd43690, 18'sd65535);
    for (int i = 0; i < 16; i++)
      applyStimulus(18'sd43690, 2'b11, 18'sd65535, i == 15);

    // Three blocks of +-0.5 scale 4-PAM (outer 65536, inner 21845), balanced per block.
    for (int k = 0; k < 48; k++) begin
      if (k % 16 == 0)
        expectRef(18'sd43690, 18'sd65535);
      neg  = lfsr[0];
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (k % 2 == 0) begin
        ob   = lfsr[0];
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        outer = ob;
      end else begin
        outer = ~ob;
      end
      case ({neg, outer})
        2'b00:   begin sl = 2'b11; x =  18'sd21845; dv =  18'sd21845; end
        2'b01:   begin sl = 2'b10; x =  18'sd65536; dv =  18'sd65535; end
        2'b10:   begin sl = 2'b01; x = -18'sd21845; dv = -18'sd21845; end
        default: begin sl = 2'b00; x = -18'sd65536; dv = -18'sd65535; end
      endcase
      applyStimulus(x, sl, dv, (k % 16) == 15);
    end
    sym_en = 1'b0;

    for (int i = 0; i < 20 && (expQ.size() != 0 || refQ.size() != 0); i++)
      @(posedge clk);
    #1;
    checkOutput("pendingOutputs", expQ.size(), 0);
    checkOutput("pendingRefs",    refQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
